// File: rtl/decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | decoder_pkg : decoded instruction record shared by decoder and issue       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package decoder_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       r_rs1;
    logic       r_rs2;
    logic       w_rd;
    logic       r_flags;
    logic       w_flags;
    logic       branch;
    logic       undefined;
  } decoded_t;

endpackage

`default_nettype wire

// File: rtl/issue_pkg.sv
// +----------------------------------------------------------------------------+
// | issue_pkg : issue controller state encoding and register-file constants    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package issue_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    HALT    = 2'd2
  } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/issue_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | issue_ctrl_if : decoder, execute, writeback and status signals of issue    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface issue_ctrl_if;

  logic                 in_valid;
  decoder_pkg::decoded_t in_dec;
  logic                 in_ready;
  logic                 out_valid;
  decoder_pkg::decoded_t out_dec;
  logic                 out_ready;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic                 wb_flags;
  logic                 ret_valid;
  logic                 br_resolve;
  logic                 illegal;
  logic                 halted;
  logic                 clear_halt;

  modport slave (
    input  in_valid, in_dec, out_ready, wb_valid, wb_rd, wb_flags,
           ret_valid, br_resolve, clear_halt,
    output in_ready, out_valid, out_dec, illegal, halted
  );

  modport master (
    output in_valid, in_dec, out_ready, wb_valid, wb_rd, wb_flags,
           ret_valid, br_resolve, clear_halt,
    input  in_ready, out_valid, out_dec, illegal, halted
  );

endinterface

`default_nettype wire

// File: rtl/issue_ctrl_reg_scoreboard.sv
// +----------------------------------------------------------------------------+
// | reg_scoreboard : busy bits for registers and flags, RAW/WAW hazard output  |
// | ISSUE_WB_BYPASS_EN lets same-cycle writebacks release hazards.  Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_scoreboard
  import issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              set_flags_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_rd_i,
  input  logic              clr_flags_i,
  input  logic              rs1_en_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic              rs2_en_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              rd_en_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flags_en_i,
  output logic              hazard_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d, busy_chk, set_mask, clr_mask;
  logic                flags_busy_q, flags_busy_d, flags_chk;

  // Set is applied after clear so a same-cycle set/clear leaves the bit busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask[set_rd_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_rd_i] = 1'b1;
    set_mask[0]  = 1'b0;
    busy_d       = (busy_q & ~clr_mask) | set_mask;
    flags_busy_d = (flags_busy_q & ~clr_flags_i) | set_flags_i;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign busy_chk  = busy_q & ~clr_mask;
  assign flags_chk = flags_busy_q & ~clr_flags_i;
`else
  assign busy_chk  = busy_q;
  assign flags_chk = flags_busy_q;
`endif

  assign hazard_o = (rs1_en_i   && busy_chk[rs1_i]) ||
                    (rs2_en_i   && busy_chk[rs2_i]) ||
                    (rd_en_i    && busy_chk[rd_i])  ||
                    (flags_en_i && flags_chk);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= '0;
      flags_busy_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      flags_busy_q <= flags_busy_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | issue_ctrl : single-entry issue stage with hazard stall, branch serialising|
// | and undefined-instruction halt. Option: ISSUE_WB_BYPASS_EN.  Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module issue_ctrl
  import issue_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_ctrl_if.slave  bus
);

  import decoder_pkg::*;

  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             out_valid_q;
  decoded_t         out_dec_q;
  decoded_t         dec;
  logic             sb_hazard, full, hazard, slot_free, issue, trap, retire;

  assign dec       = bus.in_dec;
  assign retire    = bus.ret_valid && (inflight_q != '0);
  assign slot_free = !out_valid_q || bus.out_ready;

`ifdef ISSUE_WB_BYPASS_EN
  assign full = (inflight_q == CNT_W'(MAX_INFLIGHT)) && !retire;
`else
  assign full = (inflight_q == CNT_W'(MAX_INFLIGHT));
`endif

  assign hazard = sb_hazard || full;

  reg_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (issue && dec.w_rd),
    .set_rd_i    (dec.rd),
    .set_flags_i (issue && dec.w_flags),
    .clr_en_i    (bus.wb_valid),
    .clr_rd_i    (bus.wb_rd),
    .clr_flags_i (bus.wb_flags),
    .rs1_en_i    (dec.r_rs1),
    .rs1_i       (dec.rs1),
    .rs2_en_i    (dec.r_rs2),
    .rs2_i       (dec.rs2),
    .rd_en_i     (dec.w_rd),
    .rd_i        (dec.rd),
    .flags_en_i  (dec.r_flags || dec.w_flags),
    .hazard_o    (sb_hazard)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    trap    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.in_valid) begin
          if (dec.undefined) begin
            trap    = 1'b1;
            state_d = HALT;
          end else if (!hazard && slot_free) begin
            issue = 1'b1;
            if (dec.branch) state_d = BR_WAIT;
          end
        end
      end
      BR_WAIT: if (bus.br_resolve) state_d = RUN;
      HALT:    if (bus.clear_halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !retire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!issue && retire) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      inflight_q  <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (issue) begin
        out_dec_q   <= dec;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = issue || trap;
  assign bus.illegal   = trap;
  assign bus.halted    = (state_q == HALT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_dec   = out_dec_q;

endmodule

`default_nettype wire
